// File: rtl/bpred_bht_queue.sv
// Parametrised BHT branch predictor with an in-order queue of in-flight predictions.
// Optional gshare indexing is enabled by defining BPRED_GSHARE_EN.
module bpred_bht_queue #(
  parameter int PC_W     = 16,
  parameter int IDX_W    = 4,
  parameter int CTR_W    = 2,
  parameter int CTR_INIT = 2**CTR_W-1,
  parameter int DEPTH    = 4,
  parameter int HIST_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pred_valid,
  input  logic [PC_W-1:0]            pred_pc,
  output logic                       pred_ready,
  output logic                       pred_taken,
  input  logic                       res_valid,
  input  logic                       res_taken,
  input  logic                       flush,
  output logic [1:0]                 decision,
  output logic                       mispredict,
  output logic                       res_err,
  output logic [$clog2(DEPTH+1)-1:0] inflight
);

  localparam int ENTRIES = 2**IDX_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH+1);

  logic [CTR_W-1:0] ctr [ENTRIES];
  logic [IDX_W-1:0] q_idx [DEPTH];
  logic             q_pred [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic             push, pop;
  logic [IDX_W-1:0] idx, hidx;
  logic             hpred;
  logic [CTR_W-1:0] hctr, hctr_next;

`ifdef BPRED_GSHARE_EN
  logic [HIST_W-1:0] ghr;
  logic [IDX_W-1:0]  ghr_ext;

  always_comb begin
    ghr_ext = '0;
    ghr_ext[HIST_W-1:0] = ghr;
  end

  assign idx = pred_pc[IDX_W-1:0] ^ ghr_ext;

  // History advances only on a real resolve; flush leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ghr <= '0;
    else if (pop) ghr <= {ghr[HIST_W-2:0], res_taken};
  end
`else
  assign idx = pred_pc[IDX_W-1:0];
`endif

  generate
    if (PC_W > IDX_W) begin : g_pc_hi
      logic unused_pc_hi;
      assign unused_pc_hi = ^pred_pc[PC_W-1:IDX_W];
    end
  endgenerate

  assign pred_ready = (count != CNT_W'(DEPTH));
  assign pred_taken = ctr[idx][CTR_W-1];
  assign push       = pred_valid & pred_ready & ~flush;
  assign pop        = res_valid & (count != '0);
  assign hidx       = q_idx[head];
  assign hpred      = q_pred[head];
  assign hctr       = ctr[hidx];
  assign inflight   = count;

  // NOTE: every variable in an always_comb gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    hctr_next = hctr;
    if (res_taken && (hctr != '1))       hctr_next = hctr + CTR_W'(1);
    else if (!res_taken && (hctr != '0)) hctr_next = hctr - CTR_W'(1);
  end

  // NOTE: the counter table is a reset memory (all entries start at CTR_INIT), so it is built from flops with async reset rather than RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_W'(CTR_INIT);
    end else if (pop) begin
      // NOTE: non-blocking assignment keeps the same-cycle push reading the pre-update counter.
      ctr[hidx] <= hctr_next;
    end
  end

  // Queue payload carries no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[tail]  <= idx;
      q_pred[tail] <= pred_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decision   <= 2'b11;
      mispredict <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      mispredict <= pop & (res_taken ^ hpred);
      res_err    <= res_valid & (count == '0);
      if (pop) decision <= {res_taken, hpred};
    end
  end

endmodule
